hazard_forward_ctrl: RTL
========================

Name: hazard_forward_ctrl

Overview:
Sequencing controller for the 8-bit pipeline's operand forwarding muxes and stall/flush controls. Keeps a shadow record of in-flight destination registers in the EX, MEM and WB stages. Decides per operand whether the EX-stage instruction takes its register-file value, the EX/MEM ALU result or the writeback result. Detects load-use hazards and taken-branch flushes. Sits beside the ID/EX pipeline register and drives the select inputs of both operand forwarding muxes.

Parameters:
REG_AW, 3, register index width (8 GPRs)
LOAD_STALL, 1, bubbles inserted on load-use hazard (legal 1..3)
ZERO_REG_EN, 0, 1 = R0 hardwired zero; never forwarded, never causes a stall

Ports:
clk  in  1  pipeline clock
rst_n  in  1  reset, asynchronous, active-low
id_valid  in  1  ID holds a real instruction
id_rs1  in  REG_AW  source 1 index of ID instruction
id_rs2  in  REG_AW  source 2 index
id_rs1_used  in  1  source 1 is read
id_rs2_used  in  1  source 2 is read
id_rd  in  REG_AW  destination index
id_reg_write  in  1  ID instruction writes rd
id_mem_read  in  1  ID instruction is a load
branch_taken  in  1  taken branch resolved in EX this cycle
ext_stall  in  1  memory busy; freeze whole pipeline
forward_a  out  2  source 1 select: 00 regfile, 01 ALU_Result (EX/MEM), 10 Result (WB); 11 never driven
forward_b  out  2  source 2 select, same encoding
stall_if  out  1  hold PC
stall_id  out  1  hold IF/ID register
flush_id  out  1  clear IF/ID register
flush_ex  out  1  load bubble into ID/EX register
stall_cnt  out  8  saturating count of load-use bubble cycles

Behaviour:
- Reset (async, rst_n=0): all shadow stages invalid; FSM=RUN; forward_a/b=00; stall/flush outputs 0; stall_cnt=0. Reset mid-stall abandons the stall with no residue.
- Shadow stage record: {valid, rd, reg_write, mem_read}; stages EX, MEM, WB.
- Advance (ext_stall=0, no hold): WB<=MEM, MEM<=EX, EX<=ID record, or bubble (valid=0) on hazard or flush.
- ext_stall=1: all state, outputs and stall_cnt frozen. Overrides every other event, including branch_taken.
- Forward decision for each used source s, computed combinationally from the ID record and registered at advance, so selects are valid while the instruction is in EX:
  - EX shadow valid, reg_write, rd==s, not a load -> 01 (this producer moves to MEM).
  - Otherwise MEM shadow valid, reg_write, rd==s -> 10 (producer moves to WB).
  - Otherwise 00.
  - Newest producer wins. Unused source, or s==0 with ZERO_REG_EN=1 -> 00.
  - When a bubble enters EX, forward_a/b load 00.
- Load-use hazard: id_valid and a used source matches EX shadow rd, where EX shadow is valid, mem_read and reg_write.
- FSM RUN:
  - On load-use hazard: stall_if=stall_id=1 and flush_ex=1 (combinational, same cycle); EX shadow <= bubble; MEM/WB advance.
  - If LOAD_STALL>1, go to STALL with cnt=LOAD_STALL-1; otherwise stay in RUN and re-evaluate next cycle. After one bubble the load is in MEM, so the consumer resolves to 10.
- FSM STALL:
  - Hold stall_if/stall_id/flush_ex=1; decrement cnt each advancing cycle.
  - At cnt==1, return to RUN. Forward decision is re-evaluated against the current shadow; a load already retired yields 00.
- stall_cnt increments once per bubble cycle; saturates at 255.
- branch_taken (advancing cycle): flush_id=1 and flush_ex=1; EX shadow <= bubble. Branch has priority over load-use: stall is dropped, FSM -> RUN.
- Simultaneous load-use and ext_stall: nothing happens until ext_stall clears, then the hazard is evaluated normally.

Decomposition:
- Shared package hazard_pkg: the FWD_REG=2'b00, FWD_ALU=2'b01, FWD_WB=2'b10 constants; the stage-record typedef; the FSM state enum {RUN, STALL}.
- One natural sub-module, fwd_select: pure comparator yielding the 2-bit select for one source; instantiated twice.

Test Plan:
- ADD R1 then SUB R2,R1,R3 back-to-back -> SUB in EX has forward_a=01, no stall, stall_cnt=0.
- ADD R1; NOP; SUB using R1 as source 2 -> forward_b=10; forward_a=00.
- LOAD R4 then ADD R5,R4,R4 (LOAD_STALL=1) -> one cycle of stall_if/stall_id/flush_ex=1; then forward_a=forward_b=10; stall_cnt=1.
- Same with LOAD_STALL=3 -> three bubble cycles; ADD gets 00 once the load has retired; stall_cnt=3.
- Load-use hazard and branch_taken in the same cycle -> flush_id=flush_ex=1, stall_if=0, FSM=RUN. Then ext_stall held 4 cycles -> all outputs constant.
- rst_n pulsed low mid-STALL -> outputs immediately 00/0, stall_cnt=0. ZERO_REG_EN=1 with writes to R0 -> forwards never select 01/10 for R0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared definitions for the operand forwarding / hazard controller.
package hazard_pkg;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_ALU = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  // Shadow records carry a fixed-width rd so the package stays independent of REG_AW (<= 8).
  localparam int unsigned REC_AW = 8;

  typedef struct packed {
    logic              valid;
    logic [REC_AW-1:0] rd;
    logic              reg_write;
    logic              mem_read;
  } stage_rec_t;

  typedef enum logic {
    RUN,
    STALL
  } state_e;

endpackage

// File: rtl/hazard_forward_ctrl_fwd_select.sv
// Per-operand comparator: forwarding select and load-use hit for one source register.
module fwd_select
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW      = 3,
  parameter int unsigned ZERO_REG_EN = 0
) (
  input  logic [REG_AW-1:0] src,
  input  logic              used,
  input  stage_rec_t        ex_rec,
  input  logic              mem_wr,
  input  logic [REC_AW-1:0] mem_rd,
  output logic [1:0]        sel,
  output logic              load_hit
);

  logic              live;
  logic              ex_match;
  logic [REC_AW-1:0] src_ext;

  always_comb begin
    src_ext  = REC_AW'(src);
    live     = used && !((ZERO_REG_EN != 0) && (src == '0));
    ex_match = live && ex_rec.valid && ex_rec.reg_write && (ex_rec.rd == src_ext);
    load_hit = ex_match && ex_rec.mem_read;
    sel      = FWD_REG;
    if (ex_match && !ex_rec.mem_read) begin
      sel = FWD_ALU;
    end else if (live && mem_wr && (mem_rd == src_ext)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Forwarding-select, load-use stall and branch-flush controller beside the ID/EX register.
module hazard_forward_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW      = 3,
  parameter int unsigned LOAD_STALL  = 1,
  parameter int unsigned ZERO_REG_EN = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              branch_taken,
  input  logic              ext_stall,
  output logic [1:0]        forward_a,
  output logic [1:0]        forward_b,
  output logic              stall_if,
  output logic              stall_id,
  output logic              flush_id,
  output logic              flush_ex,
  output logic [7:0]        stall_cnt
);

  state_e            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  stage_rec_t        ex_q, ex_d;
  stage_rec_t        id_rec;
  // WB is never a forwarding source, so the MEM record keeps only what MEM forwarding needs.
  logic              mem_wr_q, mem_wr_d;
  logic [REC_AW-1:0] mem_rd_q, mem_rd_d;
  logic [1:0]        fwd_a_q, fwd_a_d;
  logic [1:0]        fwd_b_q, fwd_b_d;
  logic [7:0]        stall_cnt_q, stall_cnt_d;
  logic [3:0]        hold_q, hold_d;

  logic [1:0]        sel_a, sel_b;
  logic              hit_a, hit_b;
  logic              load_use;
  logic              do_stall, do_flush_id, do_flush_ex;
  logic              bubble, count_bubble;
  logic [3:0]        ctl;
  logic [3:0]        ctl_out;

  fwd_select #(
    .REG_AW      (REG_AW),
    .ZERO_REG_EN (ZERO_REG_EN)
  ) u_fwd_a (
    .src      (id_rs1),
    .used     (id_rs1_used),
    .ex_rec   (ex_q),
    .mem_wr   (mem_wr_q),
    .mem_rd   (mem_rd_q),
    .sel      (sel_a),
    .load_hit (hit_a)
  );

  fwd_select #(
    .REG_AW      (REG_AW),
    .ZERO_REG_EN (ZERO_REG_EN)
  ) u_fwd_b (
    .src      (id_rs2),
    .used     (id_rs2_used),
    .ex_rec   (ex_q),
    .mem_wr   (mem_wr_q),
    .mem_rd   (mem_rd_q),
    .sel      (sel_b),
    .load_hit (hit_b)
  );

  always_comb begin
    id_rec           = '0;
    id_rec.valid     = id_valid;
    id_rec.rd        = REC_AW'(id_rd);
    id_rec.reg_write = id_reg_write;
    id_rec.mem_read  = id_mem_read;

    load_use     = id_valid && (hit_a || hit_b);
    do_stall     = 1'b0;
    do_flush_id  = 1'b0;
    do_flush_ex  = 1'b0;
    bubble       = !id_valid;
    count_bubble = 1'b0;

    state_d     = state_q;
    cnt_d       = cnt_q;
    ex_d        = ex_q;
    mem_wr_d    = mem_wr_q;
    mem_rd_d    = mem_rd_q;
    fwd_a_d     = fwd_a_q;
    fwd_b_d     = fwd_b_q;
    stall_cnt_d = stall_cnt_q;
    hold_d      = hold_q;

    if (branch_taken) begin
      do_flush_id = 1'b1;
      do_flush_ex = 1'b1;
      bubble      = 1'b1;
      state_d     = RUN;
      cnt_d       = '0;
    end else if (state_q == STALL) begin
      do_stall     = 1'b1;
      do_flush_ex  = 1'b1;
      bubble       = 1'b1;
      count_bubble = 1'b1;
      cnt_d        = cnt_q - 2'd1;
      if (cnt_q == 2'd1) begin
        state_d = RUN;
      end
    end else if (load_use) begin
      do_stall     = 1'b1;
      do_flush_ex  = 1'b1;
      bubble       = 1'b1;
      count_bubble = 1'b1;
      if (LOAD_STALL > 1) begin
        state_d = STALL;
        cnt_d   = 2'(LOAD_STALL - 1);
      end
    end

    ctl = {do_stall, do_stall, do_flush_id, do_flush_ex};

    if (ext_stall) begin
      state_d = state_q;
      cnt_d   = cnt_q;
    end else begin
      ex_d     = bubble ? '0 : id_rec;
      mem_wr_d = ex_q.valid && ex_q.reg_write;
      mem_rd_d = ex_q.rd;
      fwd_a_d  = bubble ? FWD_REG : sel_a;
      fwd_b_d  = bubble ? FWD_REG : sel_b;
      if (count_bubble && (stall_cnt_q != 8'hFF)) begin
        stall_cnt_d = stall_cnt_q + 8'd1;
      end
      hold_d = ctl;
    end
  end

  // While the pipeline is frozen the controls replay the last advancing cycle.
  always_comb begin
    ctl_out = ext_stall ? hold_q : ctl;
    if (!rst_n) begin
      ctl_out = '0;
    end
  end

  assign stall_if  = ctl_out[3];
  assign stall_id  = ctl_out[2];
  assign flush_id  = ctl_out[1];
  assign flush_ex  = ctl_out[0];
  assign forward_a = fwd_a_q;
  assign forward_b = fwd_b_q;
  assign stall_cnt = stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      cnt_q       <= '0;
      ex_q        <= '0;
      mem_wr_q    <= 1'b0;
      mem_rd_q    <= '0;
      fwd_a_q     <= FWD_REG;
      fwd_b_q     <= FWD_REG;
      stall_cnt_q <= '0;
      hold_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ex_q        <= ex_d;
      mem_wr_q    <= mem_wr_d;
      mem_rd_q    <= mem_rd_d;
      fwd_a_q     <= fwd_a_d;
      fwd_b_q     <= fwd_b_d;
      stall_cnt_q <= stall_cnt_d;
      hold_q      <= hold_d;
    end
  end

endmodule
